// File: rtl/spi_slave_with_modes.sv
// SPI receive endpoint: oversamples sclk/mosi/cs in the clk domain and recovers
// one MSB-first DATA_W-bit frame per cs assertion, flagging early-terminated frames.
module spi_slave_with_modes #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              cs,
  output logic [DATA_W-1:0] dout,
  output logic              done,
  output logic              busy,
  output logic              err
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic                   sclk_hist_q, sclk_hist_d;
  logic                   cs_hist_q, cs_hist_d;
  logic [SYNC_STAGES:0]   vld_q, vld_d;
  state_t                 state_q, state_d;
  logic [1:0]             mode_q, mode_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]      shreg_q, shreg_d;
  logic [DATA_W-1:0]      dout_q, dout_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;

  logic sclk_s, mosi_s, cs_s;
  logic cs_fall, cs_rise, samp, last_bit;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];

  // vld_q marks which pipeline stages hold real pin samples since reset, so a
  // frame already in progress at reset release is not mistaken for a new cs fall.
  assign cs_fall  = vld_q[SYNC_STAGES] & cs_hist_q & ~cs_s;
  assign cs_rise  = ~cs_hist_q & cs_s;
  assign samp     = (sclk_s ^ sclk_hist_q) & (sclk_s == ~(mode_q[1] ^ mode_q[0]));
  assign last_bit = (cnt_q == CNT_W'(DATA_W - 1));

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
    sclk_hist_d = sclk_s;
    cs_hist_d   = cs_s;
    vld_d       = {vld_q[SYNC_STAGES-1:0], 1'b1};
    state_d     = state_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    dout_d      = dout_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cs_fall) begin
          mode_d  = mode;
          shreg_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // The final sampling edge beats a coincident cs rise; any other bit is dropped.
        if (samp && last_bit) begin
          shreg_d = DATA_W'({shreg_q, mosi_s});
          cnt_d   = cnt_q + CNT_W'(1);
          dout_d  = shreg_d;
          done_d  = 1'b1;
          state_d = cs_rise ? IDLE : HOLD;
        end else if (cs_rise) begin
          err_d   = (cnt_q != '0);
          state_d = IDLE;
        end else if (samp) begin
          shreg_d = DATA_W'({shreg_q, mosi_s});
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (cs_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync_q <= {SYNC_STAGES{mode[1]}};
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_hist_q <= mode[1];
      cs_hist_q   <= 1'b1;
      vld_q       <= '0;
      state_q     <= IDLE;
      mode_q      <= 2'b00;
      cnt_q       <= '0;
      shreg_q     <= '0;
      dout_q      <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_sync_q   <= cs_sync_d;
      sclk_hist_q <= sclk_hist_d;
      cs_hist_q   <= cs_hist_d;
      vld_q       <= vld_d;
      state_q     <= state_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      dout_q      <= dout_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign dout = dout_q;
  assign done = done_q;
  assign busy = busy_q;
  assign err  = err_q;

endmodule

// File: tb/tb_spi_slave_with_modes.sv
// Directed bench for spi_slave_with_modes: drives SPI frames in all four modes
// and checks captured bytes, strobes, busy, abort, reset and mode latching.
module tb_spi_slave_with_modes;

  logic       clk;
  logic       rst_n;
  logic [1:0] mode;
  logic       sclk;
  logic       mosi;
  logic       cs;
  logic [7:0] dout;
  logic       done;
  logic       busy;
  logic       err;

  int total = 0;
  int bad   = 0;

  int         done_cnt;
  int         err_cnt;
  logic [7:0] done_val;
  logic [1:0] model_mode;
  logic [7:0] right_sh;
  logic [7:0] wrong_sh;
  logic       sclk_prev;

  spi_slave_with_modes #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .mode (mode),
    .sclk (sclk),
    .mosi (mosi),
    .cs   (cs),
    .dout (dout),
    .done (done),
    .busy (busy),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe counters plus two wire-level decoders: one on the correct edge, one on the opposite edge.
  always @(negedge clk) begin
    if (done) begin
      done_cnt = done_cnt + 1;
      done_val = dout;
    end
    if (err) err_cnt = err_cnt + 1;
    if (!cs && (sclk != sclk_prev)) begin
      if (sclk == ~(model_mode[1] ^ model_mode[0])) right_sh = {right_sh[6:0], mosi};
      else                                          wrong_sh = {wrong_sh[6:0], mosi};
    end
    sclk_prev = sclk;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Master model: mosi changes on the shift edge (cpha=1: one clk after it), sclk half period = 2 clk.
  task automatic spi_frame(input logic [1:0] m, input logic [15:0] bits, input int n,
                           input int rst_at, input int sw_at, input logic [1:0] sw_mode);
    logic cpol, cpha;
    cpol = m[1];
    cpha = m[0];
    done_cnt = 0; err_cnt = 0;
    right_sh = '0; wrong_sh = '0;
    model_mode = m;
    mode = m; sclk = cpol; mosi = 1'b0;
    tick(3);
    cs = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!cpha) mosi = bits[n-1-i];
      tick(2);
      sclk = ~cpol;
      if (cpha) begin
        tick(1); mosi = bits[n-1-i]; tick(1);
      end else begin
        tick(2);
      end
      sclk = cpol;
      if (i + 1 == sw_at) mode = sw_mode;
      if (i + 1 == rst_at) begin
        rst_n = 1'b0;
        tick(1);
        chk("rst_mid_outputs", {dout, done, busy, err}, 32'h0);
        rst_n = 1'b1;
      end
    end
    if (!cpha) mosi = 1'b0;
    tick(2);
    chk("busy_in_frame", busy, (rst_at == 0) ? 1 : 0);
    cs = 1'b1;
    tick(6);
    chk("busy_after_frame", busy, 0);
  endtask

  task automatic expect_frame(input string tag, input int exp_done, input int exp_err,
                              input logic [7:0] exp_dout);
    chk({tag, "_done_cnt"}, done_cnt, exp_done);
    chk({tag, "_err_cnt"}, err_cnt, exp_err);
    chk({tag, "_dout"}, dout, exp_dout);
    if (exp_done != 0) chk({tag, "_done_val"}, done_val, exp_dout);
  endtask

  task automatic expect_edges(input string tag, input logic [7:0] sent);
    chk({tag, "_model_right"}, right_sh, sent);
    chk({tag, "_wrong_edge_differs"}, (wrong_sh != dout) ? 1 : 0, 1);
  endtask

  initial begin
    rst_n = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; mode = 2'b00;
    done_cnt = 0; err_cnt = 0; done_val = '0;
    model_mode = 2'b00; right_sh = '0; wrong_sh = '0; sclk_prev = 1'b0;
    tick(3);
    chk("reset_outputs", {dout, done, busy, err}, 32'h0);
    rst_n = 1'b1;
    tick(4);

    spi_frame(2'b00, 16'h00A5, 8, 0, 0, 2'b00);
    expect_frame("mode0_a5", 1, 0, 8'hA5);
    expect_edges("mode0_a5", 8'hA5);

    spi_frame(2'b00, 16'h001F, 5, 0, 0, 2'b00);
    expect_frame("abort_ff", 0, 1, 8'hA5);

    spi_frame(2'b00, 16'h0012, 8, 0, 0, 2'b00);
    expect_frame("after_abort_12", 1, 0, 8'h12);

    spi_frame(2'b01, 16'h003C, 8, 0, 0, 2'b01);
    expect_frame("mode1_3c", 1, 0, 8'h3C);
    expect_edges("mode1_3c", 8'h3C);

    spi_frame(2'b10, 16'h00C3, 8, 0, 0, 2'b10);
    expect_frame("mode2_c3", 1, 0, 8'hC3);
    expect_edges("mode2_c3", 8'hC3);

    spi_frame(2'b11, 16'h0081, 8, 0, 0, 2'b11);
    expect_frame("mode3_81", 1, 0, 8'h81);
    expect_edges("mode3_81", 8'h81);

    spi_frame(2'b00, 16'h05AF, 12, 0, 0, 2'b00);
    expect_frame("extra_clocks_5a", 1, 0, 8'h5A);

    spi_frame(2'b00, 16'h00E7, 8, 3, 0, 2'b00);
    expect_frame("reset_mid_frame", 0, 0, 8'h00);

    spi_frame(2'b00, 16'h007E, 8, 0, 0, 2'b00);
    expect_frame("after_reset_7e", 1, 0, 8'h7E);

    spi_frame(2'b00, 16'h0096, 8, 0, 4, 2'b01);
    expect_frame("mode_switch_cur_96", 1, 0, 8'h96);

    spi_frame(2'b01, 16'h0069, 8, 0, 0, 2'b01);
    expect_frame("mode_switch_next_69", 1, 0, 8'h69);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
